// File: rtl/tpg_vip_stream_gen.sv
// ---------------------------------------------------------------------------
// tpg_vip_stream_gen
// Purpose: self-contained VIP Avalon-ST test pattern generator. Each frame is
//   a control packet (width / line count / interlace nibbles) followed by a
//   video packet of width x lines pixel beats. Four pattern modes, interlaced
//   field alternation and ready-latency-0 backpressure are supported.
// Optional feature macro: TPG_MOVING_BARS_EN (mode 3 = colour bars that shift
//   by one pixel every OFFSET_FRAMES frames). Undefined: mode 3 = mode 0.
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-low reset
//   enable_i      run request (level)
//   mode_i        0 bars, 1 gradient, 2 solid, 3 moving bars
//   width_i       active pixels per line
//   height_i      lines per frame (progressive) or per interlaced frame
//   interlaced_i  1 = alternate F0/F1 fields
//   color_i       solid colour value
//   ready_i       sink ready (latency 0)
//   data_o        beat data, symbol 0 in the low bits
//   valid_o/sop_o/eop_o  stream framing
//   busy_o        high from frame start until the video eop is accepted
// ---------------------------------------------------------------------------
module tpg_vip_stream_gen #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int OFFSET_FRAMES    = 25
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        enable_i,
  input  logic [1:0]                                  mode_i,
  input  logic [15:0]                                 width_i,
  input  logic [15:0]                                 height_i,
  input  logic                                        interlaced_i,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] color_i,
  input  logic                                        ready_i,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_o,
  output logic                                        valid_o,
  output logic                                        sop_o,
  output logic                                        eop_o,
  output logic                                        busy_o
);
  localparam int B  = BITS_PER_SYMBOL;
  localparam int S  = SYMBOLS_PER_BEAT;
  localparam int DW = B * S;
  localparam int NB = (9 + S - 1) / S;  // control body beats

  // State names the beat currently held in the output register.
  typedef enum logic [2:0] {ST_IDLE, ST_CTRL_HDR, ST_CTRL_BODY, ST_VID_HDR, ST_VID_DATA} state_e;

  state_e state_q, state_d;
  logic [DW-1:0] data_q, data_d, color_q, color_d;
  logic valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, busy_q, busy_d;
  logic ilace_q, ilace_d, field_q, field_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] w_q, w_d, lines_q, lines_d, x_q, x_d, y_q, y_d;
`ifdef TPG_MOVING_BARS_EN
  logic [15:0] phase_q, phase_d, fcnt_q, fcnt_d;
  logic [16:0] sum_s;
`endif

  logic [3:0]    ctrl_idx_s;
  logic [15:0]   pix_x_s, pix_y_s, bw_s, new_lines_s;
  logic [3:0]    nib_s [9];
  logic [DW-1:0] body_s, pix_s;
  logic [16:0]   xs_s;
  logic [19:0]   thr_s;
  logic [2:0]    bar_s, code_s;
  logic accept_s, start_ok_s, frame_end_s, start_s, cur_field_s, eff_field_s;
  int            idx_s;

  function automatic logic [2:0] bar_code(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_code = 3'd7;
      3'd1:    bar_code = 3'd6;
      3'd2:    bar_code = 3'd3;
      3'd3:    bar_code = 3'd2;
      3'd4:    bar_code = 3'd5;
      3'd5:    bar_code = 3'd4;
      3'd6:    bar_code = 3'd1;
      default: bar_code = 3'd0;
    endcase
  endfunction

  // Coordinates of the beat that would be loaded on the next acceptance.
  always_comb begin
    if (state_q == ST_CTRL_BODY) ctrl_idx_s = cnt_q + 4'd1;
    else                         ctrl_idx_s = 4'd0;
    if (state_q == ST_VID_DATA && x_q != w_q - 16'd1) pix_x_s = x_q + 16'd1;
    else                                              pix_x_s = 16'd0;
    if (state_q == ST_VID_DATA && x_q == w_q - 16'd1) pix_y_s = y_q + 16'd1;
    else if (state_q == ST_VID_DATA)                  pix_y_s = y_q;
    else                                              pix_y_s = 16'd0;
  end

  // Control body beat: nine nibbles packed into symbol low nibbles.
  always_comb begin
    nib_s[0] = w_q[15:12];     nib_s[1] = w_q[11:8];
    nib_s[2] = w_q[7:4];       nib_s[3] = w_q[3:0];
    nib_s[4] = lines_q[15:12]; nib_s[5] = lines_q[11:8];
    nib_s[6] = lines_q[7:4];   nib_s[7] = lines_q[3:0];
    if (!ilace_q)     nib_s[8] = 4'b0000;
    else if (field_q) nib_s[8] = 4'b1100;
    else              nib_s[8] = 4'b1000;
    body_s = '0;
    idx_s  = 0;
    for (int k = 0; k < S; k++) begin
      idx_s = int'(ctrl_idx_s) * S + k;
      if (idx_s < 9) body_s[k*B +: 4] = nib_s[idx_s[3:0]];
      else           body_s[k*B +: 4] = 4'd0;
    end
  end

  // Pixel value for the next pixel coordinate; bar index by threshold compare.
  always_comb begin
    if (w_q[15:3] == 13'd0) bw_s = 16'd1;
    else                    bw_s = {3'd0, w_q[15:3]};
    xs_s = {1'b0, pix_x_s};
`ifdef TPG_MOVING_BARS_EN
    sum_s = {1'b0, pix_x_s} + {1'b0, phase_q};
    if (mode_q == 2'd3) begin
      if (sum_s >= {1'b0, w_q}) xs_s = sum_s - {1'b0, w_q};
      else                      xs_s = sum_s;
    end else begin
      xs_s = {1'b0, pix_x_s};
    end
`endif
    bar_s = 3'd0;
    thr_s = 20'd0;
    for (int k = 1; k < 8; k++) begin
      thr_s = {4'd0, bw_s} * 20'(k);
      if ({3'd0, xs_s} >= thr_s) bar_s = 3'(k);
      else                       bar_s = bar_s;
    end
    code_s = bar_code(bar_s);
    pix_s  = '0;
    case (mode_q)
      2'd1: for (int k = 0; k < S; k++) pix_s[k*B +: B] = pix_x_s[B-1:0];
      2'd2: pix_s = color_q;
      default: for (int k = 0; k < S; k++) pix_s[k*B +: B] = code_s[k % 3] ? {B{1'b1}} : {B{1'b0}};
    endcase
  end

  // Frame start qualification, field selection and line count of a new frame.
  always_comb begin
    accept_s    = valid_q && ready_i;
    start_ok_s  = enable_i && (width_i != 16'd0) && (height_i != 16'd0);
    frame_end_s = (state_q == ST_VID_DATA) && accept_s && eop_q;
    start_s     = start_ok_s && ((state_q == ST_IDLE) || frame_end_s);
    // The field toggles as an interlaced frame ends, before the next one starts.
    cur_field_s = (state_q == ST_VID_DATA && ilace_q) ? ~field_q : field_q;
    // An empty F1 (height 1) is skipped by emitting F0 instead.
    eff_field_s = interlaced_i && cur_field_s && (height_i[15:1] != 15'd0);
    if (!interlaced_i)    new_lines_s = height_i;
    else if (eff_field_s) new_lines_s = {1'b0, height_i[15:1]};
    else                  new_lines_s = 16'(({1'b0, height_i} + 17'd1) >> 1);
  end

  // Framing FSM next state and output-register loading.
  always_comb begin
    state_d = state_q;  data_d  = data_q;  valid_d = valid_q;
    sop_d   = sop_q;    eop_d   = eop_q;   busy_d  = busy_q;
    w_d     = w_q;      lines_d = lines_q; ilace_d = ilace_q;
    field_d = field_q;  mode_d  = mode_q;  color_d = color_q;
    cnt_d   = cnt_q;    x_d     = x_q;     y_d     = y_q;
`ifdef TPG_MOVING_BARS_EN
    phase_d = phase_q;  fcnt_d  = fcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef TPG_MOVING_BARS_EN
        phase_d = 16'd0;
        fcnt_d  = 16'd0;
`endif
        state_d = ST_IDLE;
      end
      ST_CTRL_HDR: begin
        if (accept_s) begin
          cnt_d = 4'd0; data_d = body_s; sop_d = 1'b0; eop_d = (NB == 1);
          state_d = ST_CTRL_BODY;
        end else begin
          state_d = state_q;
        end
      end
      ST_CTRL_BODY: begin
        if (accept_s && cnt_q == 4'(NB - 1)) begin
          data_d = '0; sop_d = 1'b1; eop_d = 1'b0; state_d = ST_VID_HDR;
        end else if (accept_s) begin
          cnt_d = cnt_q + 4'd1; data_d = body_s; eop_d = (cnt_q + 4'd1 == 4'(NB - 1));
        end else begin
          state_d = state_q;
        end
      end
      ST_VID_HDR: begin
        if (accept_s) begin
          x_d = 16'd0; y_d = 16'd0; data_d = pix_s; sop_d = 1'b0;
          eop_d = (w_q == 16'd1) && (lines_q == 16'd1);
          state_d = ST_VID_DATA;
        end else begin
          state_d = state_q;
        end
      end
      ST_VID_DATA: begin
        if (accept_s && eop_q) begin
          field_d = cur_field_s;
          state_d = ST_IDLE; valid_d = 1'b0; sop_d = 1'b0; eop_d = 1'b0;
          data_d = '0; busy_d = 1'b0;
`ifdef TPG_MOVING_BARS_EN
          if (!start_ok_s) begin
            phase_d = 16'd0; fcnt_d = 16'd0;
          end else if (fcnt_q == 16'(OFFSET_FRAMES - 1)) begin
            fcnt_d  = 16'd0;
            phase_d = (phase_q >= w_q - 16'd1) ? 16'd0 : phase_q + 16'd1;
          end else begin
            fcnt_d = fcnt_q + 16'd1;
          end
`endif
        end else if (accept_s) begin
          x_d = pix_x_s; y_d = pix_y_s; data_d = pix_s;
          eop_d = (pix_x_s == w_q - 16'd1) && (pix_y_s == lines_q - 16'd1);
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // New frame: latch configuration and load the control header beat.
    if (start_s) begin
      w_d = width_i; lines_d = new_lines_s; ilace_d = interlaced_i;
      field_d = eff_field_s; mode_d = mode_i; color_d = color_i;
      data_d = {{(DW-4){1'b0}}, 4'hF}; valid_d = 1'b1; sop_d = 1'b1; eop_d = 1'b0;
      busy_d = 1'b1; cnt_d = 4'd0; state_d = ST_CTRL_HDR;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE; data_q <= '0; valid_q <= 1'b0; sop_q <= 1'b0;
      eop_q <= 1'b0; busy_q <= 1'b0; w_q <= 16'd0; lines_q <= 16'd0;
      ilace_q <= 1'b0; field_q <= 1'b0; mode_q <= 2'd0; color_q <= '0;
      cnt_q <= 4'd0; x_q <= 16'd0; y_q <= 16'd0;
`ifdef TPG_MOVING_BARS_EN
      phase_q <= 16'd0; fcnt_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d; data_q <= data_d; valid_q <= valid_d; sop_q <= sop_d;
      eop_q <= eop_d; busy_q <= busy_d; w_q <= w_d; lines_q <= lines_d;
      ilace_q <= ilace_d; field_q <= field_d; mode_q <= mode_d; color_q <= color_d;
      cnt_q <= cnt_d; x_q <= x_d; y_q <= y_d;
`ifdef TPG_MOVING_BARS_EN
      phase_q <= phase_d; fcnt_q <= fcnt_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign busy_o  = busy_q;
endmodule

// File: tb/tb_tpg_vip_stream_gen.sv
// Scoreboard bench for tpg_vip_stream_gen: frames are predicted from the
// configuration and queued; a monitor pops and compares every accepted beat.
module tb_tpg_vip_stream_gen;
  localparam int B = 8, S = 3, DW = B * S, OFF = 2;

  logic clk = 1'b0;
  logic rst_i, enable_i, interlaced_i, ready_i;
  logic [1:0] mode_i;
  logic [15:0] width_i, height_i;
  logic [DW-1:0] color_i, data_o;
  logic valid_o, sop_o, eop_o, busy_o;

  always #5 clk = ~clk;

  tpg_vip_stream_gen #(.BITS_PER_SYMBOL(B), .SYMBOLS_PER_BEAT(S), .OFFSET_FRAMES(OFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i),
    .width_i(width_i), .height_i(height_i), .interlaced_i(interlaced_i),
    .color_i(color_i), .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o),
    .sop_o(sop_o), .eop_o(eop_o), .busy_o(busy_o));

  int tests = 0, fails = 0;
  int sop_seen = 0, acc_total = 0, cyc = 0, last_acc_cyc = 0;
  int mfield = 0, rmode = 0;
  logic [DW+1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference pixel: bar index from plain division of the (shifted) x.
  function automatic logic [DW-1:0] pixel(input int x, input int w, input int md,
                                          input logic [DW-1:0] col, input int phase);
    int code[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    int xs, bw, bi;
    logic [DW-1:0] d;
    d = '0;
    if (md == 1) begin
      for (int k = 0; k < S; k++) d[k*B +: B] = B'(x % 256);
    end else if (md == 2) begin
      d = col;
    end else begin
      xs = x;
`ifdef TPG_MOVING_BARS_EN
      if (md == 3) xs = (x + phase) % w;
`endif
      bw = w / 8; if (bw == 0) bw = 1;
      bi = xs / bw; if (bi > 7) bi = 7;
      for (int k = 0; k < S; k++) d[k*B +: B] = ((code[bi] >> (k % 3)) & 1) != 0 ? 8'hFF : 8'h00;
    end
    return d;
  endfunction

  task automatic push_frame(input int w, input int h, input int il, input int md,
                            input logic [DW-1:0] col, input int f);
    int fld, lines, nbeats, phase;
    logic [15:0] wv, lv;
    logic [3:0] nib[9];
    logic [DW-1:0] d;
    if (il == 0) begin fld = 0; lines = h; end
    else begin
      fld = mfield;
      if (fld == 1 && h / 2 == 0) fld = 0;
      lines = (fld == 1) ? h / 2 : (h + 1) / 2;
    end
    mfield = (il != 0) ? 1 - fld : 0;
    wv = 16'(w); lv = 16'(lines);
    nib[0] = wv[15:12]; nib[1] = wv[11:8]; nib[2] = wv[7:4]; nib[3] = wv[3:0];
    nib[4] = lv[15:12]; nib[5] = lv[11:8]; nib[6] = lv[7:4]; nib[7] = lv[3:0];
    nib[8] = (il == 0) ? 4'h0 : (fld == 1 ? 4'hC : 4'h8);
    exp_q.push_back({24'h00000F, 1'b1, 1'b0});
    nbeats = (9 + S - 1) / S;
    for (int c = 0; c < nbeats; c++) begin
      d = '0;
      for (int k = 0; k < S; k++) if (c * S + k < 9) d[k*B +: 4] = nib[c*S+k];
      exp_q.push_back({d, 1'b0, c == nbeats - 1});
    end
    exp_q.push_back({24'h000000, 1'b1, 1'b0});
    phase = (f / OFF) % w;
    for (int y = 0; y < lines; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back({pixel(x, w, md, col, phase), 1'b0, (x == w - 1) && (y == lines - 1)});
  endtask

  // Monitor: compare accepted beats, and check holding while stalled.
  initial begin : monitor
    logic [DW+1:0] prev, e;
    bit stalled;
    stalled = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        stalled = 0;
      end else begin
        if (stalled) check("stall_hold", {valid_o, data_o, sop_o, eop_o}, {1'b1, prev});
        if (valid_o && ready_i) begin
          acc_total++; last_acc_cyc = cyc;
          if (sop_o) sop_seen++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: actual=%0h required=none", {data_o, sop_o, eop_o});
          end else begin
            e = exp_q.pop_front();
            check("beat", {data_o, sop_o, eop_o}, e);
          end
        end
        stalled = valid_o && !ready_i;
        prev = {data_o, sop_o, eop_o};
      end
    end
  end

  // Sink ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin : ready_drv
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: ready_i = 1'b1;
        1: ready_i = ~ready_i;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic run(input int w, input int h, input int il, input int md,
                     input logic [DW-1:0] col, input int k, input int rm);
    int base, n0, c0, t;
    rmode = rm; width_i = 16'(w); height_i = 16'(h); interlaced_i = 1'(il);
    mode_i = 2'(md); color_i = col;
    for (int f = 0; f < k; f++) push_frame(w, h, il, md, col, f);
    base = sop_seen; n0 = acc_total;
    @(posedge clk); #1; enable_i = 1'b1; c0 = cyc;
    @(negedge clk); check("valid_before_sample", valid_o, 0);
    @(negedge clk); check("valid_rise", {valid_o, sop_o, busy_o}, 3'b111);
    t = 0;
    while (sop_seen < base + 2 * k - 1 && t < 20000) begin @(negedge clk); t++; end
    check("start_timeout", t < 20000, 1);
    @(posedge clk); #1; enable_i = 1'b0;
    // Configuration changes during the final frame must not affect it.
    color_i = $urandom; mode_i = 2'($urandom_range(0, 3)); width_i = 16'($urandom_range(1, 50));
    t = 0;
    while (busy_o && t < 20000) begin @(negedge clk); t++; end
    check("busy_timeout", t < 20000, 1);
    repeat (3) @(negedge clk);
    check("idle_valid", valid_o, 0);
    check("queue_empty", exp_q.size(), 0);
    if (rm == 0) check("throughput", last_acc_cyc - c0, acc_total - n0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n0, t;
    rst_i = 1'b0; enable_i = 1'b0; mode_i = 2'd0; width_i = 16'd0; height_i = 16'd0;
    interlaced_i = 1'b0; color_i = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {data_o, valid_o, sop_o, eop_o, busy_o}, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", valid_o, 0);

    run(4, 2, 0, 2, 24'h123456, 2, 0);
    run(16, 1, 0, 0, $urandom, 1, 2);
    run(300, 1, 0, 1, 24'h0, 1, 1);
    run(4, 5, 1, 1, 24'h0, 3, 2);
    run(16, 1, 0, 3, 24'h0, 4, 0);
    run(1, 1, 0, 0, 24'h0, 2, 0);
    run(3, 1, 1, 0, 24'h0, 2, 2);
    for (int i = 0; i < 8; i++)
      run($urandom_range(1, 20), $urandom_range(1, 4), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom, $urandom_range(1, 2), $urandom_range(0, 2));

    // Zero width or height keeps the generator idle.
    @(posedge clk); #1; width_i = 16'd0; height_i = 16'd4; enable_i = 1'b1;
    repeat (8) @(negedge clk);
    check("zero_width_idle", {valid_o, busy_o}, 0);
    @(posedge clk); #1; width_i = 16'd4; height_i = 16'd0;
    repeat (8) @(negedge clk);
    check("zero_height_idle", {valid_o, busy_o}, 0);
    @(posedge clk); #1; enable_i = 1'b0;

    // Asynchronous reset in the middle of a frame.
    rmode = 2; width_i = 16'd8; height_i = 16'd4; mode_i = 2'd0; interlaced_i = 1'b0;
    push_frame(8, 4, 0, 0, 24'h0, 0);
    n0 = acc_total;
    @(posedge clk); #1; enable_i = 1'b1;
    t = 0;
    while (acc_total < n0 + 10 && t < 2000) begin @(negedge clk); t++; end
    check("rst_wait_timeout", t < 2000, 1);
    @(posedge clk); #2; rst_i = 1'b0; #1;
    check("async_rst_outputs", {data_o, valid_o, sop_o, eop_o, busy_o}, 0);
    enable_i = 1'b0; exp_q.delete(); mfield = 0;
    @(negedge clk); rst_i = 1'b1;
    repeat (4) @(negedge clk);
    check("after_rst_idle", {valid_o, busy_o}, 0);

    // Interlaced run after reset starts again at F0.
    run(5, 3, 1, 1, 24'h0, 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tpg_vip_stream_gen.md
Name: tpg_vip_stream_gen

Overview:
- Self-contained, parametrised successor to the stripe generator plus control-packet-encoder pair.
- Emits complete VIP Avalon-ST frames on its own framing FSM: control packet (width/height/interlace), then video packet.
- Supports four pattern modes, configurable symbol count and width, interlaced field alternation, and backpressure.
- Sits between the Avalon-MM register block (config inputs) and the downstream VIP stream sink.

Parameters:
BITS_PER_SYMBOL, 8, bits per colour symbol (B)
SYMBOLS_PER_BEAT, 3, colour symbols per beat (S); data width = B*S
OFFSET_FRAMES, 25, frames between 1-pixel shifts in moving-bars mode (feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
enable_i  in  1  run request; level-sensitive
mode_i  in  2  0 colour bars, 1 horizontal gradient, 2 solid colour, 3 moving bars
width_i  in  16  active pixels per line
height_i  in  16  lines per frame (progressive) or per interlaced frame
interlaced_i  in  1  1 = emit alternating F0/F1 fields
color_i  in  B*S  solid-colour value
ready_i  in  1  sink ready, ready latency 0
data_o  out  B*S  stream data; symbol 0 = data_o[B-1:0]
valid_o  out  1  beat valid
sop_o  out  1  start of packet
eop_o  out  1  end of packet
busy_o  out  1  high from packet start to final eop of frame

Behaviour:
- Reset (rst_i low, async): all outputs 0; FSM IDLE; field bit 0; counters 0.
- Outputs registered. A beat is accepted when valid_o && ready_i. With valid_o high and ready_i low, data_o/sop_o/eop_o/valid_o hold stable.
- FSM: IDLE -> CTRL_HDR -> CTRL_BODY -> VID_HDR -> VID_DATA -> (CTRL_HDR if enable_i else IDLE).
- IDLE: when enable_i=1, width_i!=0 and height_i!=0, latch width, height, interlaced, mode and color, then load the header beat. valid_o rises the cycle after enable_i is sampled high. Zero width or height: remain IDLE.
- CTRL_HDR beat: data = 0xF in symbol 0 low nibble, all else 0; sop_o=1.
- CTRL_BODY: 9 nibbles in order w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], ilace.
  - Each nibble sits in the low 4 bits of successive symbols, symbol 0 first.
  - ceil(9/S) beats; unused symbols and upper bits are 0; eop_o on the last beat.
  - ilace = 4'b0000 progressive, 4'b1000 for F0, 4'b1100 for F1.
  - h = latched height when progressive; field line count when interlaced.
- Interlaced field line count: F0 = ceil(height/2), F1 = floor(height/2). If the F1 count is 0, that field is skipped.
- Field bit toggles after each interlaced frame's eop. It resets to F0 when progressive.
- VID_HDR beat: data 0, sop_o=1.
- VID_DATA: width x lines beats, x counts 0..w-1 and y counts 0..lines-1; eop_o on the final beat. Counters advance only on an accepted beat.
- Colour bars:
  - Bar width bw = max(1, width>>3). Bar index increments every bw pixels, saturates at 7, and resets each line.
  - Code table per index 0..7: 7,6,3,2,5,4,1,0 (white, yellow, cyan, green, magenta, red, blue, black).
  - Symbol k = all-ones if bit (k mod 3) of the code is set, else 0.
- Gradient: every symbol = x[B-1:0], wrapping.
- Solid: data = latched color.
- Mode 3 without the feature behaves as mode 0.
- enable_i deassertion mid-frame: the current frame completes through its video eop, then IDLE. Config changes mid-frame are ignored until the next frame.
- busy_o is 1 from the IDLE exit until acceptance of the video eop beat.
- Throughput: 1 beat/clock with ready_i held high; no bubbles between packets or frames.

Optional Feature:
- Macro TPG_MOVING_BARS_EN.
- Defined: mode 3 shifts the bar pattern by a phase register (0..width-1), added modulo width to x before bar indexing.
  - A frame counter increments at each video eop. When it reaches OFFSET_FRAMES-1, the phase increments (wrapping at width) and the counter clears.
  - Both the phase and the counter clear on reset and in IDLE.
- Undefined: no phase/counter logic; mode 3 equals mode 0.

Test Plan:
- B=8, S=3, w=4, h=2, progressive, mode 2, color=0x123456, ready=1. Required beats, one per cycle (13 total), then repeat while enabled:
  - 0x00000F sop
  - 0x000000, 0x000004, 0x000200 eop
  - 0x000000 sop
  - 8 beats of 0x123456, last with eop
- w=16, h=1, mode 0: pixel pairs are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 (symbol 2 leftmost).
- ready_i toggled 1/0 each cycle, mode 1, w=300: data/sop/eop stable while stalled; gradient wraps 255 -> 0 at x=256; 300 pixel beats with eop on the last.
- interlaced=1, h=5: first ctrl packet has h nibbles 0,0,0,3 and ilace 0x8, with 3 lines; second has h=2, ilace 0xC, 2 lines; third returns to F0.
- enable_i dropped during VID_DATA line 0: frame finishes with eop, busy_o falls, valid_o stays 0. rst_i low mid-frame: all outputs 0 immediately.
- With TPG_MOVING_BARS_EN, OFFSET_FRAMES=2, mode 3, w=16: frames 0-1 match the mode-0 pattern; frames 2-3 are shifted by 1 pixel (x=0 takes bar of x=1).
